// File: rtl/dwt_soft_threshold_if.sv
// Coefficient-pair bus into the soft-threshold stage and its results back out.
interface dwt_soft_threshold_if #(
  parameter int unsigned DW = 32
);
  logic          in_valid;
  logic [DW-1:0] an_in;
  logic [DW-1:0] dn_in;
  logic          thr_en;
  logic          out_valid;
  logic [DW-1:0] an_out;
  logic [DW-1:0] dn_out;
  logic [DW-2:0] thr_out;
  logic          win_done;

  // Source of coefficients (lifting stage or testbench).
  modport master (
    output in_valid, an_in, dn_in, thr_en,
    input  out_valid, an_out, dn_out, thr_out, win_done
  );

  // The thresholding stage itself.
  modport slave (
    input  in_valid, an_in, dn_in, thr_en,
    output out_valid, an_out, dn_out, thr_out, win_done
  );
endinterface

// File: rtl/dwt_soft_threshold.sv
// Soft-thresholds the detail coefficient of each DWT pair against an adaptive noise threshold
// derived from the mean |dn| of fixed-length windows; the approximation passes through, delay
// matched. Three register stages, full throughput, no backpressure.
module dwt_soft_threshold #(
  parameter int unsigned DW       = 32,
  parameter int unsigned WIN_LOG2 = 6,
  parameter int unsigned THR_NUM  = 12,
  parameter int unsigned THR_INIT = 64
) (
  input logic               clk,
  input logic               rst_n,
  dwt_soft_threshold_if.slave bus
);

  localparam int unsigned AccW  = DW - 1 + WIN_LOG2;
  localparam int unsigned ProdW = DW - 1 + 32;
  localparam logic [DW-2:0] ThrMax = '1;

  // Stage 1 registers
  logic          s1_valid;
  logic [DW-1:0] s1_an, s1_dn;
  logic [DW-2:0] s1_abs;
  logic          s1_thr_en;
  // Stage 2 registers
  logic          s2_valid;
  logic [DW-1:0] s2_an, s2_dn;
  logic [DW-2:0] s2_mag;
  logic          s2_thr_en;
  // Output registers
  logic          out_valid_q, win_done_q;
  logic [DW-1:0] an_out_q, dn_out_q;
  // Window statistics
  logic [AccW-1:0]     acc_q;
  logic [WIN_LOG2-1:0] cnt_q;
  logic [DW-2:0]       thr_q;

  // Combinational helpers
  logic [DW-2:0]      dn_neg, abs_d, mag_d, mean, thr_new;
  logic [AccW-1:0]    acc_sum;
  logic [ProdW-1:0]   prod;
  logic [ProdW-4:0]   scaled;
  logic               win_end;
  logic [DW-1:0]      mag_ext, dn_res;

  // |dn| with the most negative code saturated to the largest positive magnitude.
  always_comb begin
    dn_neg = -bus.dn_in[DW-2:0];
    abs_d  = bus.dn_in[DW-2:0];
    if (bus.dn_in[DW-1]) begin
      abs_d = (bus.dn_in[DW-2:0] == '0) ? ThrMax : dn_neg;
    end
  end

  // Shrink magnitude by the current threshold, and compute the next threshold at window end.
  always_comb begin
    mag_d   = (s1_abs > thr_q) ? s1_abs - thr_q : '0;
    acc_sum = acc_q + AccW'(s1_abs);
    mean    = acc_sum[AccW-1:WIN_LOG2];
    prod    = ProdW'(mean) * ProdW'(THR_NUM);
    scaled  = prod[ProdW-1:3];
    thr_new = (scaled > (ProdW-3)'(ThrMax)) ? ThrMax : scaled[DW-2:0];
    win_end = s1_valid && (cnt_q == '1);
  end

  // Reapply the original sign to the shrunk magnitude, or bypass when thresholding is off.
  always_comb begin
    mag_ext = {1'b0, s2_mag};
    dn_res  = s2_dn;
    if (s2_thr_en) begin
      dn_res = s2_dn[DW-1] ? -mag_ext : mag_ext;
    end
  end

  // Stage 1: capture the pair and its saturated magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_an     <= '0;
      s1_dn     <= '0;
      s1_abs    <= '0;
      s1_thr_en <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_an     <= bus.an_in;
        s1_dn     <= bus.dn_in;
        s1_abs    <= abs_d;
        s1_thr_en <= bus.thr_en;
      end
    end
  end

  // Stage 2: subtract the threshold in force on this edge (old value on an update edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_an     <= '0;
      s2_dn     <= '0;
      s2_mag    <= '0;
      s2_thr_en <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_an     <= s1_an;
        s2_dn     <= s1_dn;
        s2_mag    <= mag_d;
        s2_thr_en <= s1_thr_en;
      end
    end
  end

  // Stage 3: registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      an_out_q    <= '0;
      dn_out_q    <= '0;
    end else begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        an_out_q <= s2_an;
        dn_out_q <= dn_res;
      end
    end
  end

  // Window statistics: accumulate |dn| per valid sample, refresh the threshold every window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      thr_q      <= (DW-1)'(THR_INIT);
      win_done_q <= 1'b0;
    end else begin
      win_done_q <= win_end;
      if (win_end) begin
        acc_q <= '0;
        cnt_q <= '0;
        thr_q <= thr_new;
      end else if (s1_valid) begin
        acc_q <= acc_sum;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.an_out    = an_out_q;
  assign bus.dn_out    = dn_out_q;
  assign bus.thr_out   = thr_q;
  assign bus.win_done  = win_done_q;

endmodule

// File: tb/tb_dwt_soft_threshold.sv
// Randomized bench for dwt_soft_threshold against a count-based behavioural model.
module tb_dwt_soft_threshold;

  localparam longint MaxMag = 64'd2147483647;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dwt_soft_threshold_if #(.DW(32)) bus ();

  dwt_soft_threshold #(
    .DW(32), .WIN_LOG2(6), .THR_NUM(12), .THR_INIT(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] an;
    logic [31:0] dn;
  } exp_t;

  exp_t        exp_q[$];
  bit          v_at[int];
  bit          wd_at[int];
  logic [30:0] thr_at[int];

  int          cyc = 0;
  bit          chk_on = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  int          m_cnt;
  longint      m_sum;
  longint      m_thr;
  logic [30:0] thr_shown;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts and reports.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    v_at.delete();
    wd_at.delete();
    thr_at.delete();
    m_cnt     = 0;
    m_sum     = 0;
    m_thr     = 64;
    thr_shown = 31'd64;
  endtask

  // Reference: threshold depends only on how many complete windows precede the sample.
  task automatic model_push(input logic [31:0] an, input logic [31:0] dn, input bit en);
    longint d, a, mag, r, mean, t;
    exp_t   e;
    d = longint'($signed(dn));
    a = (d < 0) ? -d : d;
    if (a > MaxMag) a = MaxMag;
    mag = (a > m_thr) ? a - m_thr : 0;
    r = !en ? d : ((d < 0) ? -mag : mag);
    e.an = an;
    e.dn = r[31:0];
    exp_q.push_back(e);
    v_at[cyc + 3] = 1'b1;
    m_sum += a;
    m_cnt++;
    if (m_cnt == 64) begin
      mean = m_sum / 64;
      t = (mean * 12) / 8;
      if (t > MaxMag) t = MaxMag;
      m_thr = t;
      thr_at[cyc + 2] = t[30:0];
      wd_at[cyc + 2]  = 1'b1;
      m_cnt = 0;
      m_sum = 0;
    end
  endtask

  task automatic apply(input bit v, input logic [31:0] an, input logic [31:0] dn, input bit en);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.an_in    = an;
    bus.dn_in    = dn;
    bus.thr_en   = en;
    if (v) model_push(an, dn, en);
  endtask

  task automatic idle(input int n);
    repeat (n) apply(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    #2;
    rst_n        = 1'b0;
    chk_on       = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_an_out", bus.an_out, 0);
    check_eq("rst_dn_out", bus.dn_out, 0);
    check_eq("rst_win_done", bus.win_done, 0);
    check_eq("rst_thr_out", bus.thr_out, 64);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;
  endtask

  function automatic logic [31:0] sgn(input bit neg, input logic [31:0] m);
    return neg ? -m : m;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      bit   exp_v;
      exp_t e;
      exp_v = v_at.exists(cyc);
      check_eq("out_valid", bus.out_valid, exp_v);
      if (bus.out_valid && exp_v && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("an_out", bus.an_out, e.an);
        check_eq("dn_out", bus.dn_out, e.dn);
      end
      if (thr_at.exists(cyc)) thr_shown = thr_at[cyc];
      check_eq("win_done", bus.win_done, wd_at.exists(cyc));
      check_eq("thr_out", bus.thr_out, thr_shown);
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.an_in    = '0;
    bus.dn_in    = '0;
    bus.thr_en   = 1'b0;
    model_reset();
    do_reset();

    // Latency and sign / edge cases against the initial threshold.
    apply(1'b1, 32'd1000, 32'd200, 1'b1);
    idle(4);
    apply(1'b1, 32'd1, sgn(1'b1, 32'd200), 1'b1);
    apply(1'b1, 32'd2, 32'd64, 1'b1);
    apply(1'b1, 32'd3, sgn(1'b1, 32'd10), 1'b1);
    apply(1'b1, 32'd4, sgn(1'b1, 32'd10), 1'b0);
    idle(4);

    // Reset with samples in flight.
    for (int i = 0; i < 5; i++) apply(1'b1, $urandom, $urandom, 1'b1);
    do_reset();
    idle(3);

    // Full window of |dn|=80, then a sample under the new threshold.
    for (int i = 0; i < 64; i++) apply(1'b1, $urandom, sgn($urandom_range(0, 1) == 1, 32'd80), 1'b1);
    apply(1'b1, 32'd77, 32'd200, 1'b1);
    idle(4);
    check_eq("t4_thr", bus.thr_out, 120);

    // Same window with random gaps.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      idle($urandom_range(0, 3));
      apply(1'b1, $urandom, sgn($urandom_range(0, 1) == 1, 32'd80), 1'b1);
    end
    idle($urandom_range(0, 3));
    apply(1'b1, 32'd78, 32'd200, 1'b1);
    idle(4);
    check_eq("t5_gap_thr", bus.thr_out, 120);

    // Zero threshold, most-negative input, then a saturating window.
    do_reset();
    for (int i = 0; i < 64; i++) apply(1'b1, $urandom, 32'd0, 1'b1);
    idle(2);
    check_eq("t5_zero_thr", bus.thr_out, 0);
    apply(1'b1, 32'd5, 32'h8000_0000, 1'b1);
    for (int i = 0; i < 63; i++) apply(1'b1, $urandom, sgn($urandom_range(0, 1) == 1, 32'h7fff_ffff), 1'b1);
    idle(4);
    check_eq("t5_sat_thr", bus.thr_out, 31'h7fff_ffff);

    // Random scoreboard run.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      bit          v;
      logic [31:0] d;
      v = ($urandom_range(0, 9) < 7);
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = -d;
      if ($urandom_range(0, 499) == 0) d = 32'h8000_0000;
      apply(v, $urandom, d, $urandom_range(0, 7) != 0);
    end
    idle(6);
    check_eq("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
